// File: rtl/drain_requant_packer_pkg.sv
// Shared types and constants for the column drain requantiser: precision modes,
// widths, per-mode lane geometry, saturation limits and small datapath helpers.
`ifndef ACC_WIDTH
`define ACC_WIDTH 64
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

package drain_requant_packer_pkg;

  typedef enum logic [1:0] {
    MODE_INT4  = 2'd0,
    MODE_INT8  = 2'd1,
    MODE_INT16 = 2'd2,
    MODE_RSVD  = 2'd3
  } precision_mode_t;

  localparam int ACC_W  = `ACC_WIDTH;
  localparam int DATA_W = `DATA_WIDTH;
  localparam int PROD_W = ACC_W + 16;
  localparam int EXT_W  = PROD_W + 1;

  localparam int LANE_W_INT4  = 4;
  localparam int LANE_W_INT8  = 8;
  localparam int LANE_W_INT16 = 16;

  localparam int LANES_INT4  = 4;
  localparam int LANES_INT8  = 2;
  localparam int LANES_INT16 = 1;

  localparam int INT4_MIN  = -8;
  localparam int INT4_MAX  = 7;
  localparam int INT8_MIN  = -128;
  localparam int INT8_MAX  = 127;
  localparam int INT16_MIN = -32768;
  localparam int INT16_MAX = 32767;

  function automatic logic [2:0] lanes_per_word(input precision_mode_t m);
    case (m)
      MODE_INT4: lanes_per_word = 3'(LANES_INT4);
      MODE_INT8: lanes_per_word = 3'(LANES_INT8);
      default:   lanes_per_word = 3'(LANES_INT16);
    endcase
  endfunction

  function automatic logic [3:0] lane_shift(input precision_mode_t m, input logic [2:0] cnt);
    case (m)
      MODE_INT4: lane_shift = 4'(32'(cnt) * LANE_W_INT4);
      MODE_INT8: lane_shift = 4'(32'(cnt) * LANE_W_INT8);
      default:   lane_shift = 4'(32'(cnt) * LANE_W_INT16);
    endcase
  endfunction

  // Clamp to the lane range, then zero the bits above the lane width.
  function automatic logic [DATA_W-1:0] sat_lane(input logic signed [EXT_W-1:0] v,
                                                 input precision_mode_t m);
    logic signed [EXT_W-1:0] lo;
    logic signed [EXT_W-1:0] hi;
    logic [DATA_W-1:0] r;
    case (m)
      MODE_INT4: begin lo = EXT_W'(INT4_MIN);  hi = EXT_W'(INT4_MAX);  end
      MODE_INT8: begin lo = EXT_W'(INT8_MIN);  hi = EXT_W'(INT8_MAX);  end
      default:   begin lo = EXT_W'(INT16_MIN); hi = EXT_W'(INT16_MAX); end
    endcase
    if (v < lo)      r = lo[DATA_W-1:0];
    else if (v > hi) r = hi[DATA_W-1:0];
    else             r = v[DATA_W-1:0];
    case (m)
      MODE_INT4: sat_lane = {12'h000, r[3:0]};
      MODE_INT8: sat_lane = {8'h00, r[7:0]};
      default:   sat_lane = r;
    endcase
  endfunction

endpackage

// File: rtl/drain_requant_packer_sync_fifo.sv
// Generic synchronous FIFO, head entry visible at rd_dat; push while full is
// accepted only if a pop happens in the same cycle.
module drain_requant_packer_sync_fifo #(
  parameter int DW    = 16,
  parameter int DEPTH = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] push_dat,
  input  logic          pop,
  output logic [DW-1:0] rd_dat,
  output logic          full,
  output logic          empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic          wr_en;
  logic          rd_en;

  assign full   = (cnt == (AW+1)'(DEPTH));
  assign empty  = (cnt == '0);
  assign wr_en  = push && (!full || pop);
  assign rd_en  = pop && !empty;
  assign rd_dat = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      cnt <= cnt + (AW+1)'(wr_en) - (AW+1)'(rd_en);
    end
  end

endmodule

// File: rtl/drain_requant_packer.sv
// Column drain requantiser: scale/round/saturate 64-bit accs and pack SWAR lanes into 16-bit words; 3-cycle
// acc-to-out_valid latency, no input backpressure, FIFO drops on overflow. NPU_OUT_RELU_EN clamps negatives to 0.
`ifndef ACC_WIDTH
`define ACC_WIDTH 64
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

module drain_requant_packer
  import drain_requant_packer_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int SHIFT_W    = 6
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  precision_mode_t        cfg_mode,
  input  logic [15:0]            cfg_scale,
  input  logic [SHIFT_W-1:0]     cfg_shift,
  input  logic                   acc_valid,
  input  logic [`ACC_WIDTH-1:0]  acc_in,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [`DATA_WIDTH-1:0] out_data,
  output logic                   busy,
  output logic                   overflow,
  output logic                   mode_err
);

  precision_mode_t          mode_q, mode_eff;
  logic signed [15:0]       scale_q, scale_eff;
  logic [SHIFT_W-1:0]       shift_q, shift_eff;

  // A start pulse applies its config to the acc arriving in the same cycle.
  assign mode_eff  = start ? cfg_mode : mode_q;
  assign scale_eff = start ? $signed(cfg_scale) : scale_q;
  assign shift_eff = start ? cfg_shift : shift_q;

  logic                     s1_vld, s1_flush;
  precision_mode_t          s1_mode;
  logic [SHIFT_W-1:0]       s1_shift;
  logic signed [PROD_W-1:0] s1_prod;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q   <= MODE_INT16;
      scale_q  <= 16'sd1;
      shift_q  <= '0;
      s1_vld   <= 1'b0;
      s1_flush <= 1'b0;
      s1_mode  <= MODE_INT16;
      s1_shift <= '0;
      s1_prod  <= '0;
      mode_err <= 1'b0;
    end else begin
      if (start) begin
        mode_q  <= cfg_mode;
        scale_q <= $signed(cfg_scale);
        shift_q <= cfg_shift;
      end
      s1_vld   <= acc_valid && (mode_eff != MODE_RSVD);
      s1_flush <= flush;
      s1_mode  <= mode_eff;
      s1_shift <= shift_eff;
      s1_prod  <= PROD_W'($signed(acc_in)) * PROD_W'(scale_eff);
      mode_err <= (mode_err && !start) || (acc_valid && (mode_eff == MODE_RSVD));
    end
  end

  logic [6:0]              rnd_idx;
  logic signed [EXT_W-1:0] rnd, rsum, shifted;

  always_comb begin
    rnd     = '0;
    rnd_idx = 7'(s1_shift) - 7'd1;
    if (s1_shift != '0) rnd[rnd_idx] = 1'b1;
    rsum    = EXT_W'(s1_prod) + rnd;
    shifted = rsum >>> s1_shift;
`ifdef NPU_OUT_RELU_EN
    if (shifted < 0) shifted = '0;
`endif
  end

  logic                    s2_vld, s2_flush;
  precision_mode_t         s2_mode;
  logic [DATA_W-1:0]       s2_lane;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_vld   <= 1'b0;
      s2_flush <= 1'b0;
      s2_mode  <= MODE_INT16;
      s2_lane  <= '0;
    end else begin
      s2_vld   <= s1_vld;
      s2_flush <= s1_flush;
      s2_mode  <= s1_mode;
      s2_lane  <= sat_lane(shifted, s1_mode);
    end
  end

  logic [2:0]        pack_cnt, cnt_inc, cnt_nxt;
  logic [DATA_W-1:0] pack_word, word_ins, word_nxt, push_dat;
  logic              push, pop, fifo_full, fifo_empty;

  assign cnt_inc  = pack_cnt + 3'd1;
  assign word_ins = pack_word | (s2_lane << lane_shift(s2_mode, pack_cnt));

  // A flush that trails the last lane closes a partial word; an empty packer pushes nothing.
  always_comb begin
    push     = 1'b0;
    push_dat = pack_word;
    cnt_nxt  = pack_cnt;
    word_nxt = pack_word;
    if (s2_vld) begin
      cnt_nxt  = cnt_inc;
      word_nxt = word_ins;
    end
    if (s2_vld && (cnt_inc == lanes_per_word(s2_mode))) begin
      push     = 1'b1;
      push_dat = word_ins;
      cnt_nxt  = '0;
      word_nxt = '0;
    end else if (s2_flush && (cnt_nxt != '0)) begin
      push     = 1'b1;
      push_dat = word_nxt;
      cnt_nxt  = '0;
      word_nxt = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pack_cnt  <= '0;
      pack_word <= '0;
      overflow  <= 1'b0;
    end else begin
      pack_cnt  <= start ? '0 : cnt_nxt;
      pack_word <= start ? '0 : word_nxt;
      overflow  <= (overflow && !start) || (push && fifo_full && !pop);
    end
  end

  assign pop       = out_valid && out_ready;
  assign out_valid = !fifo_empty;
  assign busy      = s1_vld || s2_vld || s1_flush || s2_flush || (pack_cnt != '0) || !fifo_empty;

  drain_requant_packer_sync_fifo #(
    .DW    (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_dat (push_dat),
    .pop      (pop),
    .rd_dat   (out_data),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

endmodule

// File: doc/drain_requant_packer.md
Name: drain_requant_packer

Overview:
- Sits at the bottom of each PE column in the systolic array and consumes the 64-bit accumulators drained out of the column, one per cycle.
- Each accumulator is scaled, rounded, saturated and converted to the active precision.
- Results are packed SWAR-style into 16-bit words (4×INT4, 2×INT8 or 1×INT16), matching the PE input packing format.
- Packed words are buffered in a FIFO and presented on a valid/ready interface to the output writeback.

Parameters:
- FIFO_DEPTH, 8, packed-word FIFO entries; power of two, ≥2.
- SHIFT_W, 6, width of the right-shift amount (0..63).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  pulse: latch config, clear packer/flags
- cfg_mode  in  precision_mode_t  precision, latched on start
- cfg_scale  in  16  signed multiplier, latched on start
- cfg_shift  in  SHIFT_W  arithmetic right shift, latched on start
- acc_valid  in  1  acc_in valid this cycle (no backpressure; tied to drain_enable column output)
- acc_in  in  `ACC_WIDTH  signed accumulator from the bottom PE
- flush  in  1  pulse: emit partial word zero-padded
- out_valid  out  1  out_data valid
- out_ready  in  1  consumer accepts
- out_data  out  `DATA_WIDTH  packed word
- busy  out  1  pipeline, packer or FIFO non-empty
- overflow  out  1  sticky: word dropped because FIFO full
- mode_err  out  1  sticky: acc_valid while latched mode is MODE_RSVD

Behaviour:
- Reset: all outputs 0; FIFO empty; pack count 0; config = MODE_INT16, scale 1, shift 0.
- Stage 1 (registered): prod = acc_in × scale, signed, 80 bits.
- Stage 2 (registered):
  - If shift>0, add 1<<(shift−1), i.e. round-half-up toward +inf.
  - Arithmetic right shift by shift.
  - Saturate to lane range: INT4 [−8,7], INT8 [−128,127], INT16 [−32768,32767].
  - Insert the lane at bits [lane×W +: W], where lane = pack count, W = 4/8/16.
  - Lane 0 occupies the LSBs.
- Word complete when pack count reaches 4/2/1 lanes.
  - The complete word is written to the FIFO; pack count wraps to 0 and the word register clears.
- Latency: with the FIFO empty, out_valid rises 3 cycles after the acc_valid cycle of the word's last lane.
- FIFO:
  - Registered output; pop on out_valid&&out_ready.
  - Simultaneous push and pop when full is legal: no drop.
  - Push when full without a pop: word dropped, overflow←1.
- flush:
  - Marks the current stream end. Any acc_valid in the same cycle is included.
  - When that last lane leaves stage 2, a partial word (count>0) is pushed with unused lanes 0. With count==0, nothing is pushed.
- start:
  - Clears pack count, word register, overflow and mode_err, and latches config.
  - Does not clear FIFO contents.
  - acc_valid in the same cycle is processed with the new config.
  - Items already in stages 1–2 complete with the old config.
- MODE_RSVD: accepted accs discarded, mode_err←1, nothing pushed.
- Config inputs are ignored except on start.
- busy = any stage valid || count≠0 || pending flush || FIFO non-empty.
- Reset mid-operation: all state discarded immediately.

Optional Feature:
- NPU_OUT_RELU_EN defined: after rounding/shift and before saturation, negative values become 0.
- Undefined: signed saturation only.
- Affects only the stage-2 datapath; latency is unchanged.

Decomposition:
- Shared package (defines.sv): precision_mode_t (existing), `ACC_WIDTH/`DATA_WIDTH, per-mode lane-width and lanes-per-word constants, saturation min/max constants.
- One natural sub-module: sync_fifo (DATA_WIDTH × FIFO_DEPTH, full/empty, registered output), reusable across the output path.

Test Plan:
- INT8, scale 1, shift 0: accs 5, −3 → one word 0xFD05, out_valid 3 cycles after 2nd acc.
- INT8 saturation: accs 300, −300 → 0x807F.
- INT16, scale 1, shift 1 rounding: acc 5 → 0x0003; acc −5 → 0xFFFE.
- INT4 partial: accs 1, 2, 3, flush with the 3rd → single word 0x0321; busy falls after pop.
- Backpressure: out_ready=0, INT16, FIFO_DEPTH+1 accs → FIFO_DEPTH words retained, overflow=1; start clears overflow, FIFO data intact.
- With NPU_OUT_RELU_EN, INT8: accs −7, 9 → 0x0900; without the macro → 0x09F9.
